// File: rtl/layer_line_fetch.sv
// layer_line_fetch
//   Per-scanline layer qualification sequencer. On a start pulse it walks layer
//   indices 0..31 through a shared read address (layer_addr). For each layer it
//   checks the enable bit, the Y start and the height against the latched line.
//   Each hit is pushed as {layer, row} into a small output FIFO, and the
//   compositor drains that FIFO with a valid/ready handshake.
//
//   Ports:
//     clk          sole clock, rising edge
//     reset        synchronous active-low reset
//     start        one-cycle pulse; starts a scan when the block is idle
//     line         current line, latched when start is accepted
//     layer_addr   layer index to both register memories (0 outside SCAN)
//     ctrl_data    register-0 read data: bit15 enable, [LINE_W-1:0] Y start
//     height_data  register-1 read data: [LINE_W-1:0] height
//     out_valid    FIFO head valid
//     out_ready    compositor accepts the head entry
//     out_layer    head entry layer index
//     out_row      head entry row within the layer (line - Y)
//     busy         high in SCAN and DONE
//     done         one-cycle pulse in the DONE state
//     hit_count    pushes in the current or last scan (LAYER_FETCH_STATS_EN only)
//
//   Optional feature macro: LAYER_FETCH_STATS_EN (adds the hit_count port).
module layer_line_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int LINE_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LINE_W-1:0] line,
    output logic [4:0]        layer_addr,
    input  logic [15:0]       ctrl_data,
    input  logic [15:0]       height_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_layer,
    output logic [LINE_W-1:0] out_row,
    output logic              busy,
`ifdef LAYER_FETCH_STATS_EN
    output logic              done,
    output logic [5:0]        hit_count
`else
    output logic              done
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state_reg;
    logic [4:0]          idx_reg;
    logic [LINE_W-1:0]   line_reg;

    logic [4:0]          fifo_layer [FIFO_DEPTH];
    logic [LINE_W-1:0]   fifo_row   [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [PTR_W:0]      count_reg;

    // Range check is done one bit wider than the fields so Y + height never wraps.
    logic [LINE_W:0]     y_ext;
    logic [LINE_W:0]     end_ext;
    logic [LINE_W:0]     line_ext;
    logic [LINE_W-1:0]   row;
    logic                scanning;
    logic                hit;
    logic                full;
    logic                push;
    logic                pop;
    logic                advance;

    assign y_ext    = {1'b0, ctrl_data[LINE_W-1:0]};
    assign end_ext  = y_ext + {1'b0, height_data[LINE_W-1:0]};
    assign line_ext = {1'b0, line_reg};
    assign row      = line_reg - ctrl_data[LINE_W-1:0];

    assign scanning = (state_reg == SCAN);
    assign hit      = ctrl_data[15] && (line_ext >= y_ext) && (line_ext < end_ext);
    // Full is taken from the registered count, so a pop in the same cycle does
    // not make room for this cycle's push.
    assign full     = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
    assign push     = scanning && hit && !full;
    assign advance  = scanning && (!hit || !full);
    assign pop      = out_valid && out_ready;

    assign layer_addr = scanning ? idx_reg : 5'd0;
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign out_valid  = (count_reg != '0);
    // Gate the head so an empty FIFO presents zeros, not stale storage.
    assign out_layer  = out_valid ? fifo_layer[rd_ptr_reg] : 5'd0;
    assign out_row    = out_valid ? fifo_row[rd_ptr_reg]   : '0;

    // Upper field bits of the register words are not used by this block.
    logic unused_bits;
    assign unused_bits = &{1'b0, ctrl_data[14:LINE_W], height_data[15:LINE_W]};

    // FIFO storage has no reset; the occupancy count defines valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_layer[wr_ptr_reg] <= idx_reg;
            fifo_row[wr_ptr_reg]   <= row;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            idx_reg    <= 5'd0;
            line_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        line_reg  <= line;
                        idx_reg   <= 5'd0;
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    if (advance) begin
                        idx_reg <= idx_reg + 5'd1;
                        if (idx_reg == 5'd31) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

`ifdef LAYER_FETCH_STATS_EN
    logic [5:0] hit_cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_cnt_reg <= 6'd0;
        end else if (state_reg == IDLE && start) begin
            hit_cnt_reg <= 6'd0;
        end else if (push) begin
            hit_cnt_reg <= hit_cnt_reg + 6'd1;
        end
    end

    assign hit_count = hit_cnt_reg;
`endif

endmodule

// File: doc/layer_line_fetch.md
# layer_line_fetch

Per-scanline layer qualification sequencer. It sits directly downstream of the per-register layer memories. It walks layer indices 0..31 through a shared read address and checks each layer's enable, Y start and height against the current line. It pushes hits into a small output FIFO that the compositor drains over a valid/ready handshake.

## Interface
Parameters:
- FIFO_DEPTH, 4: output FIFO entries; power of two, 2..16.
- LINE_W, 10: width of line, Y start and height fields.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse at start of line; begins a scan.
- line  in  LINE_W  current line; sampled when start is accepted.
- layer_addr  out  5  layer index driven to readAddr1 of both register memories.
- ctrl_data  in  16  register-0 memory readData1: bit15 enable, bits[LINE_W-1:0] Y start.
- height_data  in  16  register-1 memory readData1: bits[LINE_W-1:0] height.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  compositor accepts head.
- out_layer  out  5  layer index of head entry.
- out_row  out  LINE_W  line minus Y start for head entry (row inside layer).
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse when scan completes.
- hit_count  out  6  only with LAYER_FETCH_STATS_EN.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE -> SCAN: on start=1. Latch line into line_q; idx=0.
- In IDLE, start is ignored unless in IDLE; start during SCAN/DONE is dropped.
- SCAN: layer_addr=idx. Memory reads are asynchronous, so data is evaluated in the same cycle.
- Hit condition, with 11-bit (LINE_W+1) unsigned arithmetic and no wrap:
  - ctrl_data[15]=1
  - line_q >= Y
  - line_q < Y + height
- A zero height is never a hit.
- Hit with FIFO not full: push {idx, line_q - Y} and advance idx.
- Hit with FIFO full: stall; idx holds and no push. Full is evaluated on the pre-edge count; a same-cycle pop does not free a slot for the push.
- Non-hit: idx advances regardless of FIFO state.
- After idx 31 is resolved: go to DONE. DONE lasts one cycle with done=1, then IDLE.
- FIFO:
  - out_valid = (count != 0). out_layer/out_row present the head entry.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop keeps count unchanged.
  - Entries emerge in ascending layer order.
  - FIFO contents persist across scans until popped.
- Reset values:
  - state IDLE, idx 0, layer_addr 0, line_q 0.
  - FIFO empty: out_valid 0, out_layer 0, out_row 0.
  - busy 0, done 0, hit_count 0.
- Reset mid-scan aborts the scan and discards FIFO contents; done is not emitted.

## Timing
- start sampled at edge k: SCAN is active from cycle k+1. Without stalls, idx 0..31 occupy cycles k+1..k+32, done=1 in cycle k+33, IDLE from k+34.
- Each stall cycle extends the scan by one cycle.
- A push at edge n gives out_valid=1 in cycle n+1 (if the FIFO was empty). There is no combinational path from ctrl_data to out_*.
- out_ready→pop effect is one edge; out_valid may depend combinationally only on the registered count.
- busy is high from k+1 through the DONE cycle inclusive.
- layer_addr holds 0 in IDLE and DONE.

## Configuration
- LAYER_FETCH_STATS_EN defined:
  - A 6-bit hit counter clears on start acceptance and increments per push.
  - hit_count shows the running value and holds the final total from DONE until the next start. Max 32.
- Not defined: no counter and no hit_count port. All other behaviour is identical.

## Test plan
- Single hit: layer 5 ctrl=16'h8064 (Y=100), height=10, all others disabled, line=105, out_ready=1 -> one entry {5, 5}; done at cycle k+33; no other entries.
- Boundaries: layer 0 Y=100 height=10. Line 99 -> no hit; 100 -> row 0; 109 -> row 9; 110 -> no hit. Y=1020 height=10 line=1023 -> hit row 3 (no wrap).
- Backpressure: all 32 layers enabled, Y=0, height=1023, line=0, FIFO_DEPTH=4, out_ready=0 for 20 cycles then 1 -> 4 entries held, idx stalls at 4; all 32 entries arrive in order 0..31; done after last push.
- Disabled/zero height: enable=1 height=0, or enable=0 with a valid range -> no pushes; scan completes in exactly 32 SCAN cycles.
- Reset mid-scan: reset=0 at SCAN idx 10 with 3 entries queued -> next cycle IDLE, out_valid=0, busy=0, no done; a new start runs a clean scan.
- Stats (LAYER_FETCH_STATS_EN): 7 hitting layers -> hit_count=7 in DONE and held; the next start clears it to 0.
